// File: rtl/ec_diff_pkg.sv
// Shared constants and width helpers for the multi-channel difference-equation filter.
package ec_diff_pkg;

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_FIR  = 2'd1;
  localparam logic [1:0] MODE_BYP  = 2'd2;

  function automatic int acc_w(input int n, input int g);
    return n + g;
  endfunction

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/ec_diff_sat.sv
// Combinational saturator: clips an N+G-bit signed accumulator to N bits and flags clipping.
module ec_diff_sat #(
  parameter int N = 16,
  parameter int G = 3
) (
  input  logic [N+G-1:0] i_acc,
  output logic [N-1:0]   o_y,
  output logic           o_sat
);

  // Result is {clipped flag, N-bit value}; in range when the top G+1 bits all match the sign.
  function automatic logic [N:0] sat(input logic [N+G-1:0] a);
    logic [G:0] top;
    top = a[N+G-1:N-1];
    if ((&top) || !(|top))
      return {1'b0, a[N-1:0]};
    else if (a[N+G-1])
      return {1'b1, 1'b1, {(N-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(N-1){1'b1}}};
  endfunction

  assign {o_sat, o_y} = sat(i_acc);

endmodule

// File: rtl/ec_diff_mc.sv
// Multi-channel difference-equation filter with per-channel flop history and 1-cycle latency.
module ec_diff_mc
  import ec_diff_pkg::*;
#(
  parameter int N  = 16,
  parameter int CH = 4,
  parameter int G  = 3,
  localparam int CHW = ch_w(CH),
  localparam int AW  = acc_w(N, G)
) (
  input  logic           clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  input  logic [CHW-1:0] i_ch,
  input  logic [N-1:0]   i_x,
  input  logic [1:0]     i_mode,
  input  logic           i_clr,
  output logic           o_valid,
  output logic [CHW-1:0] o_ch,
  output logic [N-1:0]   o_y,
  output logic           o_sat
);

  logic signed [N-1:0] r_x1 [CH];
  logic signed [N-1:0] r_x2 [CH];
  logic signed [N-1:0] r_x3 [CH];
  logic signed [N-1:0] r_y1 [CH];
  logic signed [N-1:0] r_y2 [CH];

  logic           r_vld_p1;
  logic [CHW-1:0] r_ch_p1;
  logic [N-1:0]   r_y_p1;
  logic           r_sat_p1;

  logic signed [N-1:0]  w_h_x1, w_h_x2, w_h_x3, w_h_y1, w_h_y2;
  logic signed [AW-1:0] w_xe, w_x1e, w_x2e, w_x3e, w_y1e, w_y2e, w_acc;
  logic                 w_hit, w_take, w_sat;
  logic [N-1:0]         w_y;

  // Stage p0: history read for the addressed channel; a clear presents zero history.
  always_comb begin
    w_hit  = 1'b0;
    w_h_x1 = '0;
    w_h_x2 = '0;
    w_h_x3 = '0;
    w_h_y1 = '0;
    w_h_y2 = '0;
    for (int c = 0; c < CH; c++) begin
      if (i_ch == CHW'(c)) begin
        w_hit = 1'b1;
        if (!i_clr) begin
          w_h_x1 = r_x1[c];
          w_h_x2 = r_x2[c];
          w_h_x3 = r_x3[c];
          w_h_y1 = r_y1[c];
          w_h_y2 = r_y2[c];
        end
      end
    end
  end

  assign w_take = i_valid & w_hit;

  assign w_xe  = {{G{i_x[N-1]}},    i_x};
  assign w_x1e = {{G{w_h_x1[N-1]}}, w_h_x1};
  assign w_x2e = {{G{w_h_x2[N-1]}}, w_h_x2};
  assign w_x3e = {{G{w_h_x3[N-1]}}, w_h_x3};
  assign w_y1e = {{G{w_h_y1[N-1]}}, w_h_y1};
  assign w_y2e = {{G{w_h_y2[N-1]}}, w_h_y2};

  // Reserved mode 3 falls into the default (full equation).
  always_comb begin
    w_acc = w_xe;
    case (i_mode)
      MODE_FIR: w_acc = w_xe - w_x1e + w_x2e + w_x3e;
      MODE_BYP: w_acc = w_xe;
      default:  w_acc = w_xe - w_x1e + w_x2e + w_x3e + (w_y1e >>> 1) + (w_y2e >>> 2);
    endcase
  end

  ec_diff_sat #(.N(N), .G(G)) u_sat (
    .i_acc (w_acc),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  // Stage p1: registered output and history shift (masked history makes clear+sample leave only this sample).
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p1 <= 1'b0;
      r_ch_p1  <= '0;
      r_y_p1   <= '0;
      r_sat_p1 <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        r_x1[c] <= '0;
        r_x2[c] <= '0;
        r_x3[c] <= '0;
        r_y1[c] <= '0;
        r_y2[c] <= '0;
      end
    end else begin
      r_vld_p1 <= w_take;
      if (w_take) begin
        r_ch_p1  <= i_ch;
        r_y_p1   <= w_y;
        r_sat_p1 <= w_sat;
      end
      for (int c = 0; c < CH; c++) begin
        if (w_take && (i_ch == CHW'(c))) begin
          r_x1[c] <= signed'(i_x);
          r_x2[c] <= w_h_x1;
          r_x3[c] <= w_h_x2;
          r_y1[c] <= signed'(w_y);
          r_y2[c] <= w_h_y1;
        end else if (i_clr) begin
          r_x1[c] <= '0;
          r_x2[c] <= '0;
          r_x3[c] <= '0;
          r_y1[c] <= '0;
          r_y2[c] <= '0;
        end
      end
    end
  end

  assign o_valid = r_vld_p1;
  assign o_ch    = r_ch_p1;
  assign o_y     = r_y_p1;
  assign o_sat   = r_sat_p1;

endmodule

// File: tb/tb_ec_diff_mc.sv
// Directed bench for ec_diff_mc (N=16, CH=3, G=3) with hand-computed expected outputs.
module tb_ec_diff_mc;

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [1:0]  i_ch;
  logic [15:0] i_x;
  logic [1:0]  i_mode;
  logic        i_clr;
  logic        o_valid;
  logic [1:0]  o_ch;
  logic [15:0] o_y;
  logic        o_sat;

  int checks = 0;
  int errors = 0;

  ec_diff_mc #(.N(16), .CH(3), .G(3)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_ch    (i_ch),
    .i_x     (i_x),
    .i_mode  (i_mode),
    .i_clr   (i_clr),
    .o_valid (o_valid),
    .o_ch    (o_ch),
    .o_y     (o_y),
    .o_sat   (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input cycle, then sample outputs 1 time unit after the edge.
  task automatic step(input logic v, input int ch, input int x, input logic [1:0] m, input logic c);
    logic [31:0] xv;
    logic [31:0] cv;
    xv = x;
    cv = ch;
    i_valid = v;
    i_ch    = cv[1:0];
    i_x     = xv[15:0];
    i_mode  = m;
    i_clr   = c;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_clr   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int ch, input int y, input int sat);
    chk({tag, "_vld"}, int'(o_valid), 1);
    chk({tag, "_ch"},  int'(o_ch), ch);
    chk({tag, "_y"},   int'($signed(o_y)), y);
    chk({tag, "_sat"}, int'(o_sat), sat);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ch    = '0;
    i_x     = '0;
    i_mode  = 2'd0;
    i_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", int'(o_valid), 0);
    chk("rst_y",   int'($signed(o_y)), 0);
    chk("rst_sat", int'(o_sat), 0);
    chk("rst_ch",  int'(o_ch), 0);
    i_rst_n = 1'b1;

    // Impulse on ch0, mode 0: 64, -32, 64, 88
    step(1, 0, 64, 2'd0, 0); chk_out("imp0", 0, 64, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("imp1", 0, -32, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("imp2", 0, 64, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("imp3", 0, 88, 0);

    // Constant full-scale on ch1: 32767, 16383, then clipped
    step(1, 1, 32767, 2'd0, 0); chk_out("max0", 1, 32767, 0);
    step(1, 1, 32767, 2'd0, 0); chk_out("max1", 1, 16383, 0);
    step(1, 1, 32767, 2'd0, 0); chk_out("max2", 1, 32767, 1);

    // Output holds while idle
    step(0, 0, 0, 2'd0, 0);
    chk("hold_vld", int'(o_valid), 0);
    chk("hold_y",   int'($signed(o_y)), 32767);
    chk("hold_sat", int'(o_sat), 1);

    // Clear all history, then interleave ch0 impulse with ch1 zeros
    step(0, 0, 0, 2'd0, 1);
    step(1, 0, 64, 2'd0, 0); chk_out("il0a", 0, 64, 0);
    step(1, 1, 0,  2'd0, 0); chk_out("il1a", 1, 0, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("il0b", 0, -32, 0);
    step(1, 1, 0,  2'd0, 0); chk_out("il1b", 1, 0, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("il0c", 0, 64, 0);
    step(1, 1, 0,  2'd0, 0); chk_out("il1c", 1, 0, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("il0d", 0, 88, 0);

    // Clear with a sample: history restarts from this sample only
    step(1, 0, 100, 2'd0, 0);
    step(1, 0, 50,  2'd0, 0);
    step(1, 0, 64,  2'd0, 1); chk_out("clrv0", 0, 64, 0);
    step(1, 0, 0,   2'd0, 0); chk_out("clrv1", 0, -32, 0);
    // ch1 was zeroed by that clear: a zero sample must give zero
    step(1, 1, 0,   2'd0, 0); chk_out("clrv_ch1", 1, 0, 0);

    // Bypass, then out-of-range channel is dropped
    step(1, 2, -5, 2'd2, 0); chk_out("byp", 2, -5, 0);
    step(1, 3, 77, 2'd0, 0);
    chk("drop_vld", int'(o_valid), 0);
    chk("drop_y",   int'($signed(o_y)), -5);
    // History written in bypass is used after switching to mode 0: 0 + 5 + (-5>>>1 = -3) = 2
    step(1, 2, 0, 2'd0, 0); chk_out("byp_hist", 2, 2, 0);

    // Feedforward mode then full: 10, -10, then 0-0+10+0+(-5)+(2) = 7
    step(0, 0, 0, 2'd0, 1);
    step(1, 0, 10, 2'd1, 0); chk_out("fir0", 0, 10, 0);
    step(1, 0, 0,  2'd1, 0); chk_out("fir1", 0, -10, 0);
    step(1, 0, 0,  2'd0, 0); chk_out("fir2", 0, 7, 0);
    // Reserved mode 3 acts as full: 0-0+0+10+(7>>>1=3)+(-10>>>2=-3) = 10
    step(1, 0, 0,  2'd3, 0); chk_out("mode3", 0, 10, 0);

    // Negative clipping in mode 1 on ch1: 32767, then -32768-32767 clips
    step(1, 1, 32767,  2'd1, 0); chk_out("neg0", 1, 32767, 0);
    step(1, 1, -32768, 2'd1, 0); chk_out("neg1", 1, -32768, 1);

    // Asynchronous reset between edges discards output and history
    i_valid = 1'b1; i_ch = 2'd0; i_x = 16'd64; i_mode = 2'd0;
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(o_valid), 0);
    chk("arst_y",   int'($signed(o_y)), 0);
    chk("arst_sat", int'(o_sat), 0);
    i_valid = 1'b0;
    #1;
    i_rst_n = 1'b1;
    step(1, 0, 0, 2'd0, 0); chk_out("post_rst0", 0, 0, 0);
    step(1, 0, 64, 2'd0, 0); chk_out("post_rst1", 0, 64, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ec_diff_mc.md
EC_DIFF_MC -- requirements
Module: ec_diff_mc

Interface
REQ-001 SHALL have parameter N, default 16: sample width, signed two's complement, N >= 4.
REQ-002 SHALL have parameter CH, default 4: number of independent channels, 1..16.
REQ-003 SHALL have parameter G, default 3: accumulator guard bits; the accumulator is N+G bits wide.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid, input, 1 bit: input sample strobe; a sample may be presented every cycle.
REQ-007 SHALL have port i_ch, input, max(1,$clog2(CH)) bits: channel index of the input sample.
REQ-008 SHALL have port i_x, input, N bits: input sample, signed.
REQ-009 SHALL have port i_mode, input, 2 bits: 0 = full equation, 1 = feedforward only, 2 = bypass, 3 = reserved (behaves as mode 0).
REQ-010 SHALL have port i_clr, input, 1 bit: synchronous clear of all channel history.
REQ-011 SHALL have port o_valid, output, 1 bit: output sample strobe.
REQ-012 SHALL have port o_ch, output, same width as i_ch: channel index of the output sample.
REQ-013 SHALL have port o_y, output, N bits: output sample, signed.
REQ-014 SHALL have port o_sat, output, 1 bit: high when o_y was clipped.

Function
REQ-015 SHALL hold, per channel, the history registers x1, x2, x3 (past inputs) and y1, y2 (past saturated outputs).
REQ-016 Mode 0 SHALL compute acc = x - x1 + x2 + x3 + (y1>>>1) + (y2>>>2), using arithmetic (floor) shifts, sign-extended to N+G bits.
REQ-017 Mode 1 SHALL compute acc = x - x1 + x2 + x3; mode 2 SHALL compute acc = x.
REQ-018 SHALL saturate acc to the range [-2^(N-1), 2^(N-1)-1] and assert o_sat exactly when clipping occurred.
REQ-019 Latency SHALL be 1 cycle: o_valid, o_ch, o_y and o_sat are registered one cycle after the i_valid cycle.
REQ-020 o_y and o_sat SHALL hold their values while o_valid is low.
REQ-021 On an accepted sample on channel c, SHALL shift only channel c's history: x3<=x2, x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
REQ-022 The history update of REQ-021 SHALL apply in every mode, so that switching mode never corrupts history.
REQ-023 SHALL leave the history of other channels, and of all channels during i_valid-low cycles, unchanged.
REQ-024 A sample with i_ch >= CH SHALL be dropped: no o_valid and no history change.
REQ-025 With i_clr high and i_valid low, SHALL zero all history.
REQ-026 With i_clr and i_valid high in the same cycle, the sample SHALL be computed with zero history; all other channels SHALL be zeroed, and the sample's own channel SHALL then hold only this sample (x1=x, y1=y, rest zero).
REQ-027 Back-to-back samples on the same channel SHALL use the history written in the previous cycle, with no stall.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately clear all history, o_valid, o_ch, o_y and o_sat to 0.
REQ-029 After reset is released, the first i_valid SHALL be accepted on the next rising edge.
REQ-030 Reset asserted mid-stream SHALL discard any in-flight output.

Structure
REQ-031 Package ec_diff_pkg SHALL hold the mode constants (MODE_FULL, MODE_FIR, MODE_BYP) and the accumulator-width helper.
REQ-032 Sub-module ec_diff_sat SHALL provide the combinational saturator (N+G bits to N bits, plus the saturation flag).
REQ-033 Per-channel history SHALL be implemented as flop arrays indexed by i_ch, not as RAM.

Verification
REQ-034 Reset, mode 0, i_x = 64 then 0,0,0 on ch0 -> o_y = 64, -32, 64, 88.
REQ-035 Mode 0, constant i_x = 32767 on ch1 -> o_y = 32767, 16383, then 32767 with o_sat = 1 on the 3rd sample.
REQ-036 ch0 impulse 64 interleaved cycle-by-cycle with ch1 zeros -> ch1 o_y all 0; ch0 sequence identical to REQ-034.
REQ-037 After 2 samples on ch0, i_clr with i_valid high and i_x = 64 -> o_y = 64; the next zero sample gives -32.
REQ-038 Mode 2, i_x = -5 -> o_y = -5 one cycle later; i_ch = CH (with CH=3) -> no o_valid.
REQ-039 Pulse i_rst_n low mid-stream, asynchronously between edges -> o_valid and o_y are 0 before the next edge, and history is zero afterwards.
